// File: rtl/sic1_sequencer.sv
// SIC1 (SUBLEQ) instruction sequencer: fetch, operand load, subtract, write-back, branch.
// Optional single-step input enabled by defining SIC1_STEP_EN.
module sic1_sequencer #(
  parameter logic [7:0] RESET_PC = 8'd0,
  parameter logic [7:0] ADDR_MAX = 8'd252
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
`ifdef SIC1_STEP_EN
  input  logic       step,
`endif
  output logic       busy,
  output logic       halted,
  output logic [7:0] pc,
  output logic [5:0] ra_addr,
  output logic [5:0] rb_addr,
  output logic [1:0] pc_low,
  output logic [1:0] rb_byte_idx,
  input  logic [7:0] in_A,
  input  logic [7:0] in_B,
  input  logic [7:0] in_C,
  input  logic [7:0] rb_byte,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_byte
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_LOAD_A, S_LOAD_B, S_WRITE, S_HALT
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [7:0] va_q, va_d, vb_q, vb_d;
  logic [5:0] ra_q, ra_d, rb_q, rb_d;
  logic [1:0] rbi_q, rbi_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d, wr_byte_q, wr_byte_d;
  logic       busy_q, busy_d, halted_q, halted_d;
  logic       single_q, single_d;
  logic       start_c, single_c, taken_c, halt_c;
  logic [7:0] r_c;
  logic [8:0] next_pc_c;

  // Start condition from IDLE; a step request runs one instruction only
`ifdef SIC1_STEP_EN
  assign start_c  = (run | step) & ~halted_q;
  assign single_c = step;
`else
  assign start_c  = run & ~halted_q;
  assign single_c = 1'b0;
`endif

  // Subtract result, branch decision and 9-bit next PC
  assign r_c       = va_q - vb_q;
  assign taken_c   = (r_c == 8'd0) | r_c[7];
  assign next_pc_c = taken_c ? {1'b0, c_q} : ({1'b0, pc_q} + 9'd3);
  assign halt_c    = next_pc_c > {1'b0, ADDR_MAX};

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      a_q       <= 8'd0;
      b_q       <= 8'd0;
      c_q       <= 8'd0;
      va_q      <= 8'd0;
      vb_q      <= 8'd0;
      ra_q      <= 6'd0;
      rb_q      <= 6'd0;
      rbi_q     <= 2'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 8'd0;
      wr_byte_q <= 8'd0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      single_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      va_q      <= va_d;
      vb_q      <= vb_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      rbi_q     <= rbi_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_byte_q <= wr_byte_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
      single_q  <= single_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    va_d      = va_q;
    vb_d      = vb_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    rbi_d     = rbi_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_byte_d = wr_byte_q;
    halted_d  = halted_q;
    single_d  = single_q;
    case (state_q)
      S_IDLE: begin
        if (start_c) begin
          state_d  = S_FETCH;
          ra_d     = pc_q[7:2];
          rb_d     = pc_q[7:2] + 6'd1;
          single_d = single_c;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        a_d     = in_A;
        b_d     = in_B;
        c_d     = in_C;
        ra_d    = in_A[7:2];
        rb_d    = in_B[7:2];
        rbi_d   = in_B[1:0];
        state_d = S_LOAD_A;
      end
      S_LOAD_A: begin
        va_d    = rb_byte;
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        vb_d      = rb_byte;
        wr_en_d   = 1'b1;
        wr_addr_d = a_q;
        wr_byte_d = va_q - rb_byte;
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        single_d = 1'b0;
        if (halt_c) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          pc_d = next_pc_c[7:0];
          if (run && !single_q) begin
            state_d = S_FETCH;
            ra_d    = next_pc_c[7:2];
            rb_d    = next_pc_c[7:2] + 6'd1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_HALT);
  end

  // In DECODE the A operand address only exists on in_A, so it is forwarded directly
  assign rb_addr     = (state_q == S_DECODE) ? in_A[7:2] : rb_q;
  assign rb_byte_idx = (state_q == S_DECODE) ? in_A[1:0] : rbi_q;

  // Write is suppressed in a cycle where reset is asserted
  assign wr_en   = wr_en_q & rst_n;
  assign wr_addr = wr_addr_q;
  assign wr_byte = wr_byte_q;
  assign ra_addr = ra_q;
  assign pc      = pc_q;
  assign pc_low  = pc_q[1:0];
  assign busy    = busy_q;
  assign halted  = halted_q;

endmodule
